// File: rtl/ysyx_24100006_scoreboard_pkg.sv
// Shared scoreboard types and defaults: register index type, tracked-GPR count, counter width, x0 index.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ysyx_24100006_scoreboard_pkg;

    localparam int SB_NR_REG = 16;
    localparam int SB_REG_AW = 4;
    localparam int SB_CNT_W  = 2;

    typedef logic [SB_REG_AW-1:0] reg_idx_t;

    // x0 is hardwired zero: never tracked, never stalled on
    localparam reg_idx_t X0_IDX = '0;

endpackage

// File: rtl/ysyx_24100006_sb_cnt.sv
// Pending-write counter for one GPR: saturating up/down with synchronous clear.
// Latency: new value visible one cycle after inc/dec/clr.
// Backpressure: none; saturates at all-ones and at zero, inc+dec together hold.
module ysyx_24100006_sb_cnt
    import ysyx_24100006_scoreboard_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // clear wins; simultaneous inc and dec cancel; both ends saturate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/ysyx_24100006_scoreboard.sv
// GPR write scoreboard: tracks in-flight writes per register, stalls ID on RAW hazard or counter saturation.
// Latency: stall/fwd/busy combinational on current counters; counters and inflight update next edge.
// Backpressure: stall_id holds ID; optional WB bypass via YSYX_24100006_SB_BYPASS_EN.
module ysyx_24100006_scoreboard
    import ysyx_24100006_scoreboard_pkg::*;
#(
    parameter int NR_REG = SB_NR_REG,
    parameter int REG_AW = SB_REG_AW,
    parameter int CNT_W  = SB_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [REG_AW-1:0]       id_rs1,
    input  logic [REG_AW-1:0]       id_rs2,
    input  logic                    id_rs1_ren,
    input  logic                    id_rs2_ren,
    input  logic [REG_AW-1:0]       id_rd,
    input  logic                    id_wen,
    input  logic                    id_fire,
    input  logic                    wb_fire,
    input  logic [REG_AW-1:0]       wb_rd,
    input  logic                    wb_wen,
    output logic                    stall_id,
    output logic                    fwd_rs1_wb,
    output logic                    fwd_rs2_wb,
    output logic [NR_REG-1:0]       busy_vec,
    output logic [REG_AW+CNT_W-1:0] inflight
);

    localparam int                IW      = REG_AW + CNT_W;
    localparam logic [REG_AW-1:0] X0      = REG_AW'(X0_IDX);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt [NR_REG];
    logic issue, retire, same_reg;
    logic inc_eff, dec_eff;
    logic raw1_base, raw2_base, sat;
    logic byp1, byp2;

    assign issue    = id_fire && id_wen && (id_rd != X0);
    assign retire   = wb_fire && wb_wen && (wb_rd != X0);
    assign same_reg = issue && retire && (id_rd == wb_rd);

    assign cnt[0] = '0;

    for (genvar i = 1; i < NR_REG; i++) begin : g_cnt
        ysyx_24100006_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (flush),
            .inc   (issue  && (id_rd == REG_AW'(i))),
            .dec   (retire && (wb_rd == REG_AW'(i))),
            .cnt   (cnt[i])
        );
    end

    // inflight moves only when the addressed counter actually moves, so it stays equal to the sum
    assign inc_eff = issue  && !same_reg && (cnt[id_rd] != CNT_MAX);
    assign dec_eff = retire && !same_reg && (cnt[wb_rd] != '0);

    // running total of pending writes, cleared with the counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else if (flush) begin
            inflight <= '0;
        end else if (inc_eff && !dec_eff) begin
            inflight <= inflight + IW'(1);
        end else if (dec_eff && !inc_eff) begin
            inflight <= inflight - IW'(1);
        end
    end

    // one busy bit per register, straight off the counters
    always_comb begin
        busy_vec = '0;
        for (int i = 0; i < NR_REG; i++) begin
            busy_vec[i] = (cnt[i] != '0);
        end
    end

    assign raw1_base = id_rs1_ren && (id_rs1 != X0) && (cnt[id_rs1] != '0);
    assign raw2_base = id_rs2_ren && (id_rs2 != X0) && (cnt[id_rs2] != '0);
    // a full counter blocks a new writer even if WB drains it this cycle
    assign sat       = id_wen && (id_rd != X0) && (cnt[id_rd] == CNT_MAX);

`ifdef YSYX_24100006_SB_BYPASS_EN
    // last outstanding write retiring now: the source can take the WB port value
    assign byp1 = retire && (wb_rd == id_rs1) && (cnt[id_rs1] == CNT_ONE);
    assign byp2 = retire && (wb_rd == id_rs2) && (cnt[id_rs2] == CNT_ONE);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign fwd_rs1_wb = byp1;
    assign fwd_rs2_wb = byp2;
    assign stall_id   = (raw1_base && !byp1) || (raw2_base && !byp2) || sat;

`ifndef SYNTHESIS
    // retiring a register with nothing pending points at a pipeline bookkeeping bug
    retire_underflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(retire && !same_reg && !flush && (cnt[wb_rd] == '0)))
        else $error("scoreboard: retire of register with no pending write");
`endif

endmodule

// File: doc/ysyx_24100006_scoreboard.md
YSYX_24100006_SCOREBOARD -- requirements
Module: ysyx_24100006_scoreboard

Interface
- REQ-001 Parameter: NR_REG, default 16, number of architectural GPRs tracked (RV32E).
- REQ-002 Parameter: REG_AW, default 4, register index width; SHALL equal clog2(NR_REG).
- REQ-003 Parameter: CNT_W, default 2, per-register pending-write counter width; maximum in-flight writes per register is 2^CNT_W-1.
- REQ-004 Ports: clock, input, 1, single clock; all state updates on rising edge.
- REQ-005 Ports: reset, input, 1, asynchronous, active-low.
- REQ-006 Ports: flush, input, 1, synchronous; clears all pending state.
- REQ-007 Ports: id_rs1 / id_rs2, input, REG_AW, source indices of the instruction in ID.
- REQ-008 Ports: id_rs1_ren / id_rs2_ren, input, 1, source actually read.
- REQ-009 Ports: id_rd, input, REG_AW; id_wen, input, 1; destination of the instruction in ID.
- REQ-010 Ports: id_fire, input, 1, ID->EX handshake completes this cycle (valid & ready).
- REQ-011 Ports: wb_fire, input, 1; wb_rd, input, REG_AW; wb_wen, input, 1; retirement of one GPR write this cycle.
- REQ-012 Ports: stall_id, output, 1, ID SHALL not fire.
- REQ-013 Ports: fwd_rs1_wb / fwd_rs2_wb, output, 1, source data taken from the WB write port this cycle.
- REQ-014 Ports: busy_vec, output, NR_REG, bit i set when counter i is nonzero.
- REQ-015 Ports: inflight, output, REG_AW+CNT_W, total pending writes.

Function
- REQ-016 Each register i>0 SHALL hold counter cnt[i]; cnt[0] SHALL be constant 0, and x0 SHALL never be tracked or stalled on.
- REQ-017 issue = id_fire & id_wen & (id_rd!=0); retire = wb_fire & wb_wen & (wb_rd!=0).
- REQ-018 Next cycle: cnt[id_rd] SHALL increment on issue and cnt[wb_rd] SHALL decrement on retire; issue and retire to the same register in one cycle SHALL leave that counter unchanged.
- REQ-019 raw_rsN = id_rsN_ren & (id_rsN!=0) & (cnt[id_rsN]!=0), evaluated combinationally on current counters.
- REQ-020 Saturation: stall_id SHALL assert when id_wen & (id_rd!=0) & cnt[id_rd]==max, regardless of same-cycle retire.
- REQ-021 stall_id = raw_rs1 | raw_rs2 | saturation, with bypass masking per REQ-029; zero-cycle latency from inputs.
- REQ-022 id_fire asserted while stall_id=1 is a protocol violation; the bench SHALL flag it, and the design SHALL still apply REQ-018.
- REQ-023 A retire to a register whose counter is 0 SHALL leave the counter at 0 (no underflow) and SHALL be flagged under simulation assertion.
- REQ-024 flush SHALL zero all counters next cycle; issue/retire in the flush cycle SHALL be ignored; flush has priority.
- REQ-025 inflight SHALL equal the sum of cnt[1..NR_REG-1], registered alongside the counters and updated +1 / -1 / 0 consistently with REQ-018.
- REQ-026 busy_vec SHALL be derived combinationally from the counters.

Reset
- REQ-027 On reset low: all counters 0, inflight 0, busy_vec 0, stall_id 0 (given no raw), fwd outputs 0; reset asserted mid-operation SHALL discard all pending state immediately.
- REQ-028 After reset release, the first edge SHALL behave as normal operation, with no extra idle cycle.

Configuration
- REQ-029 With YSYX_24100006_SB_BYPASS_EN defined: when retire & (wb_rd==id_rsN) & cnt[id_rsN]==1, raw_rsN SHALL be masked and fwd_rsN_wb=1.
- REQ-030 Without YSYX_24100006_SB_BYPASS_EN: fwd_rs1_wb / fwd_rs2_wb SHALL be tied to 0 and raw_rsN SHALL be unmasked.

Structure
- REQ-031 A shared package SHALL hold the register index typedef, the default NR_REG / CNT_W constants, and the x0 index constant.
- REQ-032 One sub-module, ysyx_24100006_sb_cnt (single saturating up/down counter with inc, dec, clr), SHALL be instantiated NR_REG-1 times.

Verification
- REQ-033 Issue x5, then ID reads rs1=x5 -> stall_id=1 until the retire of x5; stall_id=0 the cycle after retire (same cycle if bypass is enabled, with fwd_rs1_wb=1).
- REQ-034 Issue x3 three times (CNT_W=2), then ID attempts a fourth write to x3 -> stall_id=1; retire once -> stall_id=0, busy_vec[3]=1, inflight=2.
- REQ-035 Issue and retire x7 in the same cycle with cnt[7]=1 -> cnt[7] stays 1, inflight unchanged.
- REQ-036 Issue x1, x2, x4, then flush -> next cycle busy_vec=0, inflight=0, stall_id=0; an issue in the flush cycle is dropped.
- REQ-037 ID reads x0 with id_rd=0, id_wen=1, id_fire=1 -> stall_id=0 always, no counter changes.
- REQ-038 Drive reset low while inflight=3 -> all outputs 0 asynchronously; first issue after release gives inflight=1.
